// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row scan, debounce, key strobe and 8-digit entry shift register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  cols,
  input  logic        clear,
  output logic [3:0]  rows,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] entry
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 2) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  state_t        state, state_next;
  logic [3:0]    cs_meta, cs;
  logic [1:0]    row, col, lowest_col;
  logic [CW-1:0] cnt, cnt_next;
  logic          col_bit, dwell_done, cnt_done;
  logic          accept, repeat_fire, strobe, advance_row;
  logic [3:0]    code;

  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_of = 4'h1;  4'h1: key_of = 4'h2;  4'h2: key_of = 4'h3;  4'h3: key_of = 4'hA;
      4'h4: key_of = 4'h4;  4'h5: key_of = 4'h5;  4'h6: key_of = 4'h6;  4'h7: key_of = 4'hB;
      4'h8: key_of = 4'h7;  4'h9: key_of = 4'h8;  4'hA: key_of = 4'h9;  4'hB: key_of = 4'hC;
      4'hC: key_of = 4'h0;  4'hD: key_of = 4'hF;  4'hE: key_of = 4'hE;  default: key_of = 4'hD;
    endcase
  endfunction

  assign rows       = ~(4'b0001 << row);
  assign col_bit    = cs[col];
  assign dwell_done = (cnt == SCAN_LAST);
  assign cnt_done   = (cnt == DEB_LAST);
  assign code       = key_of(row, col);

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and every register gets a value.
    if (!reset_n) begin
      state     <= SCAN;
      cs_meta   <= 4'hF;
      cs        <= 4'hF;
      cnt       <= '0;
      row       <= 2'd0;
      col       <= 2'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      entry     <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the order here.
      cs_meta   <= cols;
      cs        <= cs_meta;
      state     <= state_next;
      cnt       <= cnt_next;
      key_valid <= strobe;
      if (advance_row)
        row <= row + 2'd1;
      if (state == SCAN && dwell_done && cs != 4'hF)
        col <= lowest_col;
      if (strobe)
        key_code <= code;
      if (clear)
        entry <= 32'h0;
      else if (strobe)
        entry <= {entry[27:0], code};
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned and infers a latch.
    state_next = state;
    case (state)
      SCAN:     if (dwell_done && cs != 4'hF) state_next = DEBOUNCE;
      DEBOUNCE: if (col_bit) state_next = SCAN;
                else if (cnt_done) state_next = RELEASE;
      RELEASE:  if (col_bit && cnt_done) state_next = SCAN;
      default:  state_next = SCAN;
    endcase
  end

  always_comb begin
    accept      = (state == DEBOUNCE) && !col_bit && cnt_done;
    strobe      = accept || repeat_fire;
    advance_row = (state == SCAN && dwell_done && cs == 4'hF) || (state == DEBOUNCE && col_bit);

    // Several columns low at once: the lowest index wins.
    if (!cs[0])      lowest_col = 2'd0;
    else if (!cs[1]) lowest_col = 2'd1;
    else if (!cs[2]) lowest_col = 2'd2;
    else             lowest_col = 2'd3;

    case (state)
      SCAN:     cnt_next = dwell_done ? '0 : cnt + CW'(1);
      DEBOUNCE: cnt_next = (col_bit || cnt_done) ? '0 : cnt + CW'(1);
      RELEASE:  cnt_next = (!col_bit || cnt_done) ? '0 : cnt + CW'(1);
      default:  cnt_next = '0;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

  logic [HW-1:0] hold_cnt;
  logic          repeating;

  assign repeat_fire = (state == RELEASE) && !col_bit &&
                       (hold_cnt == (repeating ? RATE_LAST : DELAY_LAST));

  // Any released sample restarts the hold, so the first repeat always needs the full delay.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (state != RELEASE || col_bit) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (repeat_fire) begin
      hold_cnt  <= '0;
      repeating <= 1'b1;
    end else begin
      hold_cnt  <= hold_cnt + HW'(1);
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives cols, expected strobes are queued per press.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  cols, rows, key_code;
  logic        key_valid;
  logic [31:0] entry;

  logic [15:0] pressed = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_kv = 1'b0;
  logic [31:0] m_entry = '0;
  bit          ok;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] entry;
  } exp_t;
  exp_t sb_q[$];

  // Index is row*4 + col.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_RATE(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cols(cols), .clear(clear),
    .rows(rows), .key_valid(key_valid), .key_code(key_code), .entry(entry)
  );

  always #5 clk = ~clk;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void expect_key(input logic [3:0] code);
    m_entry = {m_entry[27:0], code};
    sb_q.push_back('{code: code, entry: m_entry});
  endfunction

  always @(negedge clk) begin
    if (key_valid) begin
      check("no_back_to_back", {31'b0, prev_kv}, 32'd0);
      check("strobe_expected", {31'b0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobe_code", {28'b0, key_code}, {28'b0, e.code});
        check("strobe_entry", entry, e.entry);
      end
    end
    prev_kv = key_valid;
  end

  task automatic press_set(input logic [15:0] keys, input logic [3:0] code, input int hold);
    expect_key(code);
    pressed = keys;
    repeat (hold) @(negedge clk);
    pressed = '0;
    repeat (24) @(negedge clk);
  endtask

  task automatic type_idx(input int idx, input int hold);
    press_set(16'(1) << idx, keymap[idx], hold);
  endtask

  // Returns at the falling edge right after row r becomes driven.
  task automatic wait_row(input int r, output bit found);
    logic [3:0] prev;
    found = 1'b0;
    prev = rows;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!rows[r] && prev[r]) begin
        found = 1'b1;
        break;
      end
      prev = rows;
    end
    check("wait_row_reached", {31'b0, found}, 32'd1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_entry = '0;
    check("clear_entry", entry, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and idle scanning.
    repeat (3) @(negedge clk);
    check("reset_rows", {28'b0, rows}, 32'hE);
    check("reset_key_valid", {31'b0, key_valid}, 32'd0);
    check("reset_key_code", {28'b0, key_code}, 32'd0);
    check("reset_entry", entry, 32'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("idle_rows", {28'b0, rows}, {28'b0, ~(4'b0001 << ((k / 4) % 4))});
    end
    check("idle_entry", entry, 32'h0);

    // Single press of '5'.
    expect_key(4'h5);
    pressed[5] = 1'b1;
    repeat (40) @(negedge clk);
    pressed = '0;
    wait_row(2, ok);
    repeat (10) @(negedge clk);
    check("key5_entry", entry, 32'h0000_0005);
    check("key5_code", {28'b0, key_code}, 32'h5);

    // 1,2,3,A,4,5,6,B,7 occupy indices 0..8.
    for (int i = 0; i < 9; i++) type_idx(i, 36);
    check("seq_entry", entry, 32'h23A4_56B7);

    // Bouncing 'D', then a stable hold.
    expect_key(4'hD);
    repeat (10) begin
      pressed[15] = 1'b1;
      repeat (3) @(negedge clk);
      pressed[15] = 1'b0;
      @(negedge clk);
    end
    pressed[15] = 1'b1;
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (24) @(negedge clk);
    check("bounce_code", {28'b0, key_code}, 32'hD);

    // Random keys; sometimes two in one row, where the lower column must win.
    for (int n = 0; n < 12; n++) begin
      int r, c1, c2;
      r  = $urandom_range(3);
      c1 = $urandom_range(3);
      if (c1 < 3 && $urandom_range(3) == 0) begin
        c2 = $urandom_range(3, c1 + 1);
        press_set((16'(1) << (r*4+c1)) | (16'(1) << (r*4+c2)), keymap[r*4+c1], $urandom_range(40, 32));
      end else begin
        type_idx(r*4+c1, $urandom_range(40, 32));
      end
    end
    check("random_entry", entry, m_entry);

    // Clear landing on the acceptance edge of 'E'.
    pulse_clear();
    type_idx(0, 36);
    type_idx(1, 36);
    check("pre_clear_entry", entry, 32'h12);
    sb_q.push_back('{code: 4'hE, entry: 32'h0});
    m_entry = '0;
    wait_row(3, ok);
    pressed[14] = 1'b1;
    repeat (11) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_acc_valid", {31'b0, key_valid}, 32'd1);
    check("clear_acc_entry", entry, 32'h0);
    check("clear_acc_code", {28'b0, key_code}, 32'hE);
    repeat (10) @(negedge clk);
    pressed = '0;
    repeat (24) @(negedge clk);

    // Reset asserted while '8' is being debounced.
    wait_row(2, ok);
    pressed[9] = 1'b1;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_reset_rows", {28'b0, rows}, 32'hE);
    check("mid_reset_valid", {31'b0, key_valid}, 32'd0);
    check("mid_reset_code", {28'b0, key_code}, 32'h0);
    check("mid_reset_entry", entry, 32'h0);
    pressed = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_entry = '0;
    repeat (20) @(negedge clk);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Hold '9' for 100 cycles after acceptance: repeats at held cycles 40, 56, 72, 88.
    pulse_clear();
    repeat (5) expect_key(4'h9);
    pressed[10] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (key_valid) break;
    end
    check("repeat_first_accept", {31'b0, key_valid}, 32'd1);
    repeat (100) @(negedge clk);
    pressed = '0;
    repeat (30) @(negedge clk);
    check("repeat_entry", entry, 32'h0009_9999);
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
